// File: rtl/melody_sequencer_pkg.sv
// melody_sequencer_pkg
// Shared constants and types for the autoplay melody sequencer.
//   - note index constants (rest, end-of-song marker, playable range)
//   - bit positions of the {note, dur} fields in a song ROM word
//   - FSM state encoding, also exported on the debug state port
package melody_sequencer_pkg;

    localparam logic [4:0] NOTE_REST = 5'd0;
    localparam logic [4:0] NOTE_END  = 5'd31;
    localparam logic [4:0] NOTE_MIN  = 5'd1;
    localparam logic [4:0] NOTE_MAX  = 5'd25;

    localparam int NOTE_MSB = 7;
    localparam int NOTE_LSB = 3;
    localparam int DUR_MSB  = 2;
    localparam int DUR_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    // True for notes the tone generator can sound; 0 and 26..30 are rests.
    function automatic logic is_pitched(input logic [4:0] note);
        return (note != NOTE_REST) && (note >= NOTE_MIN) && (note <= NOTE_MAX);
    endfunction

endpackage

// File: rtl/melody_sequencer_timer.sv
// seq_timer
// Loadable down-counter with enable. Load has priority over enable; the
// count stops at zero.
// Ports:
//   clk, rst    clock, synchronous active-high reset (value -> 0)
//   load        load value with load_val this cycle
//   load_val    value to load
//   en          decrement by one this cycle (when not loading)
//   value       current count (registered)
//   value_next  count the register will hold after this edge
//   expire      value == 1, i.e. this is the last counted cycle
module seq_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] value,
    output logic [W-1:0] value_next,
    output logic         expire
);

    always_comb begin
        value_next = value;
        if (load) begin
            value_next = load_val;
        end else if (en && (value != '0)) begin
            value_next = value - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else begin
            value <= value_next;
        end
    end

    assign expire = (value == W'(1));

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer
// Autoplay controller: walks an external synchronous song ROM of
// {note[7:3], dur[2:0]} words and presents one note at a time to the tone
// generator. Each slot lasts (dur+1)*UNIT_CYC cycles, the last GAP_CYC of
// which are silent for articulation. A held manual key pauses playback.
// Ports:
//   clk_1MHz, rst     clock, synchronous active-high reset
//   i_start           begin playback at address 0 (only from IDLE)
//   i_stop            abort playback, return to IDLE without o_done
//   i_loop            on end of song: 1 = replay from address 0
//   i_manual_active   1 = manual key held, sequencer pauses
//   o_rom_addr        song ROM address; i_rom_data is valid a cycle later
//   i_rom_data        ROM word
//   o_note            current note index (0 = rest)
//   o_note_valid      tone generator should sound o_note
//   o_busy            1 in every state except IDLE
//   o_done            one-cycle pulse when a non-looping song ends
//   dbg_state         current FSM state
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int UNIT_CYC = 125000,
    parameter int GAP_CYC  = 10000
) (
    input  logic              clk_1MHz,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop,
    input  logic              i_manual_active,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [7:0]        i_rom_data,
    output logic [4:0]        o_note,
    output logic              o_note_valid,
    output logic              o_busy,
    output logic              o_done,
    output state_t            dbg_state
);

    localparam int TIMER_W = $clog2(8 * UNIT_CYC + 1);

    // Valid/ready is not used here: the ROM is a fixed-latency slave and
    // i_rom_data is sampled exactly one cycle after o_rom_addr is set.

    state_t             state;
    logic               wrapped;   // address ran past the last ROM word
    logic [4:0]         rom_note;
    logic [2:0]         rom_dur;
    logic               load_end;
    logic [TIMER_W-1:0] slot_cyc;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_val;
    logic               timer_en;
    logic [TIMER_W-1:0] timer_value;
    logic [TIMER_W-1:0] timer_next;
    logic               timer_expire;
    logic               note_audible_next;

    assign rom_note = i_rom_data[NOTE_MSB:NOTE_LSB];
    assign rom_dur  = i_rom_data[DUR_MSB:DUR_LSB];
    assign load_end = wrapped || (rom_note == NOTE_END);
    assign slot_cyc = (TIMER_W'(rom_dur) + TIMER_W'(1)) * TIMER_W'(UNIT_CYC);

    // Stop clears the timer so IDLE always starts from zeroed counters.
    always_comb begin
        timer_load     = 1'b0;
        timer_load_val = '0;
        timer_en       = 1'b0;
        if (i_stop && (state != S_IDLE)) begin
            timer_load = 1'b1;
        end else if ((state == S_LOAD) && !load_end) begin
            timer_load     = 1'b1;
            timer_load_val = slot_cyc;
        end else if (state == S_PLAY) begin
            timer_en = 1'b1;
        end
    end

    seq_timer #(.W(TIMER_W)) u_timer (
        .clk        (clk_1MHz),
        .rst        (rst),
        .load       (timer_load),
        .load_val   (timer_load_val),
        .en         (timer_en),
        .value      (timer_value),
        .value_next (timer_next),
        .expire     (timer_expire)
    );

    // o_note_valid is registered, so it is judged on the timer value the
    // next PLAY cycle will show.
    assign note_audible_next = is_pitched(o_note) && (timer_next > TIMER_W'(GAP_CYC));

    always_ff @(posedge clk_1MHz) begin
        if (rst || (i_stop && (state != S_IDLE))) begin
            state        <= S_IDLE;
            o_rom_addr   <= '0;
            wrapped      <= 1'b0;
            o_note       <= NOTE_REST;
            o_note_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start && !i_stop) begin
                        state      <= S_FETCH;
                        o_rom_addr <= '0;
                        wrapped    <= 1'b0;
                        o_busy     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    if (load_end) begin
                        o_rom_addr <= '0;
                        wrapped    <= 1'b0;
                        if (i_loop) begin
                            state <= S_FETCH;
                        end else begin
                            state  <= S_IDLE;
                            o_note <= NOTE_REST;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end
                    end else begin
                        state        <= S_PLAY;
                        o_note       <= rom_note;
                        o_note_valid <= is_pitched(rom_note) && (slot_cyc > TIMER_W'(GAP_CYC));
                    end
                end
                S_PLAY: begin
                    if (timer_expire) begin
                        state        <= S_FETCH;
                        o_rom_addr   <= o_rom_addr + ADDR_W'(1);
                        o_note_valid <= 1'b0;
                        if (o_rom_addr == {ADDR_W{1'b1}}) begin
                            wrapped <= 1'b1;
                        end
                    end else if (i_manual_active) begin
                        // This PLAY cycle still counts; the timer freezes from here.
                        state        <= S_PAUSE;
                        o_note_valid <= 1'b0;
                    end else begin
                        o_note_valid <= note_audible_next;
                    end
                end
                S_PAUSE: begin
                    if (!i_manual_active) begin
                        state        <= S_PLAY;
                        o_note_valid <= note_audible_next;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer
// Directed bench for melody_sequencer with UNIT_CYC=100, GAP_CYC=10,
// ADDR_W=4 and a behavioural synchronous song ROM. Output activity is
// compressed into events: a run of valid cycles {note, silent busy cycles
// before it, run length}, or an o_done pulse {busy flag, silent cycles}.
// Expected events are queued by the stimulus and popped by the monitor.
module tb_melody_sequencer;
    import melody_sequencer_pkg::*;

    localparam int ADDR_W = 4;
    localparam int UNIT   = 100;
    localparam int GAP    = 10;

    // ---------------- clock / reset / DUT ----------------
    logic              clk;
    logic              rst;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic              manual;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [4:0]        note;
    logic              note_valid;
    logic              busy;
    logic              done;
    state_t            dbg_state;

    logic [7:0] rom [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    melody_sequencer #(.ADDR_W(ADDR_W), .UNIT_CYC(UNIT), .GAP_CYC(GAP)) dut (
        .clk_1MHz        (clk),
        .rst             (rst),
        .i_start         (start),
        .i_stop          (stop),
        .i_loop          (loop_en),
        .i_manual_active (manual),
        .o_rom_addr      (rom_addr),
        .i_rom_data      (rom_data),
        .o_note          (note),
        .o_note_valid    (note_valid),
        .o_busy          (busy),
        .o_done          (done),
        .dbg_state       (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [31:0] mk_evt(input logic [1:0] kind, input logic [4:0] n,
                                           input int pre, input int len);
        return {kind, n, pre[11:0], len[12:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_evt(input logic [31:0] obs);
        logic [31:0] expv;
        if (exp_q.size() == 0) begin
            expv = 32'hFFFF_FFFF;
        end else begin
            expv = exp_q.pop_front();
        end
        chk("event", obs, expv);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    int run_len = 0;
    int zeros   = 0;
    logic [4:0] run_note = '0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check_evt(mk_evt(busy ? 2'd3 : 2'd2, 5'd0, zeros, 0));
        end
        if (busy !== 1'b1) begin
            run_len = 0;
            zeros   = 0;
        end else if (note_valid === 1'b1) begin
            run_len++;
            run_note = note;
        end else begin
            if (run_len != 0) begin
                check_evt(mk_evt(2'd1, run_note, zeros, run_len));
                zeros   = 0;
                run_len = 0;
            end
            zeros++;
        end
    end

    // Event-level model of one pass through the ROM contents.
    task automatic expect_song(input int start_pre, input bit with_done);
        int pre;
        pre = start_pre;
        for (int i = 0; i < 16; i++) begin
            logic [4:0] n;
            int slot;
            n    = rom[i][7:3];
            slot = (int'(rom[i][2:0]) + 1) * UNIT;
            if (n == 5'd31) break;
            if (n >= 5'd1 && n <= 5'd25) begin
                exp_q.push_back(mk_evt(2'd1, n, pre, slot - GAP));
                pre = GAP + 2;
            end else begin
                pre += slot + 2;
            end
        end
        if (with_done) exp_q.push_back(mk_evt(2'd2, 5'd0, pre, 0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL %s: observed %0d events pending after %0d cycles, expected 0",
                   tag, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (note_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, note_valid}, 32'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_valid"}, {31'd0, note_valid}, 32'd0);
        chk({tag, "_note"}, {27'd0, note}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_addr"}, {28'd0, rom_addr}, 32'd0);
        chk({tag, "_state"}, {29'd0, dbg_state}, {29'd0, S_IDLE});
    endtask

    task automatic load_song1();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = {5'd13, 3'd1};
        rom[1] = {5'd0,  3'd0};
        rom[2] = {5'd25, 3'd0};
        rom[3] = {5'd31, 3'd0};
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; manual = 1'b0;
        load_song1();
        repeat (3) tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Plain song: 13 (dur 1), rest, 25, END, o_done.
        expect_song(2, 1'b1);
        pulse_start();
        wait_drain("song1", 1500);
        tick();
        chk_idle_outputs("song1_end");

        // Looping: END returns to address 0, note 13 replays, no o_done.
        loop_en = 1'b1;
        exp_q.push_back(mk_evt(2'd1, 5'd13, 2, 190));
        exp_q.push_back(mk_evt(2'd1, 5'd25, 114, 90));
        exp_q.push_back(mk_evt(2'd1, 5'd13, 14, 190));
        pulse_start();
        wait_drain("loop", 1500);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop_en = 1'b0;
        chk_idle_outputs("loop_stop");

        // Manual pause 50 cycles into note 13 for 500 cycles.
        exp_q.push_back(mk_evt(2'd1, 5'd13, 2, 50));
        exp_q.push_back(mk_evt(2'd1, 5'd13, 500, 140));
        exp_q.push_back(mk_evt(2'd1, 5'd25, 114, 90));
        exp_q.push_back(mk_evt(2'd2, 5'd0, 12, 0));
        pulse_start();
        wait_valid("pause_first_valid", 20);
        repeat (49) tick();
        manual = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick();
            chk("pause_valid", {31'd0, note_valid}, 32'd0);
            chk("pause_busy", {31'd0, busy}, 32'd1);
        end
        chk("pause_note", {27'd0, note}, 32'd13);
        manual = 1'b0;
        wait_drain("pause", 1500);
        tick();

        // Stop mid-note, then restart from address 0.
        pulse_start();
        wait_valid("stop_first_valid", 20);
        repeat (20) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_idle_outputs("stop_mid");
        exp_q.push_back(mk_evt(2'd1, 5'd13, 2, 190));
        pulse_start();
        chk("restart_addr", {28'd0, rom_addr}, 32'd0);
        chk("restart_state", {29'd0, dbg_state}, {29'd0, S_FETCH});
        wait_drain("restart", 600);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        // Start and stop together while idle: stays idle.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk_idle_outputs("start_stop");

        // Start held while busy does not restart playback.
        expect_song(2, 1'b1);
        start = 1'b1;
        repeat (300) tick();
        start = 1'b0;
        wait_drain("start_held", 1500);
        tick();
        chk_idle_outputs("start_held_end");

        // Reset during PLAY.
        pulse_start();
        wait_valid("rst_first_valid", 20);
        repeat (30) tick();
        rst = 1'b1;
        tick();
        chk_idle_outputs("rst_play");
        rst = 1'b0;
        tick();

        // No END word: address wraps after 15 and o_done pulses.
        for (int i = 0; i < 16; i++) rom[i] = {5'(i + 1), 3'd0};
        rom[3]  = {5'd26, 3'd0};
        rom[7]  = {5'd30, 3'd1};
        rom[14] = {5'd1,  3'd2};
        rom[15] = {5'd25, 3'd0};
        expect_song(2, 1'b1);
        pulse_start();
        wait_drain("wrap", 3000);
        tick();
        chk_idle_outputs("wrap_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
